ripple_cnt_seq: RTL and testbench

- Sequencer that drives an external asynchronous ripple counter (WIDTH stages, each toggling on the falling edge of the stage before it) from the synchronous clk domain.
- On start it:
  - clears the counter,
  - issues one count pulse per step up to a programmed target,
  - waits a fixed settle window after each pulse so the ripple can propagate,
  - samples the counter and checks it against a shadow count.
- Ends with a one-cycle done pulse. Sits between control logic and the ripple counter instance.

---
 rtl/ripple_cnt_seq.sv | 201 ++++++++++++++++++++
 tb/tb_ripple_cnt_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ripple_cnt_seq.sv
// ripple_cnt_seq: drives an external asynchronous ripple counter from the clk
// domain. Each run clears the counter, then issues one count pulse per step
// up to the latched target. After each clear or pulse it waits SETTLE cycles
// so the ripple can propagate, then samples the counter against a shadow count.
// A run ends with a one-cycle done pulse.
//
// Optional feature: define RIPPLE_SEQ_CHECK_EN to compare cnt_q against the
// shadow count in CCHECK/CHECK and raise the sticky error flag. When it is not
// defined, no comparison is made and error stays 0. Run timing is identical
// in both builds.
module ripple_cnt_seq #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] cnt_q,
  output logic             cnt_pulse,
  output logic             cnt_clr_n,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] count_out,
  output logic             error
);

  localparam int WAIT_W = $clog2(SETTLE + 1);

  // CLEAR lasts two cycles: load 1, then count down through 0.
  localparam logic [WAIT_W-1:0] WAIT_CLR    = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_SETTLE = WAIT_W'(SETTLE - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLEAR,
    S_CSETTLE,
    S_CCHECK,
    S_PULSE_H,
    S_PULSE_L,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   target_q;
  logic               error_q, error_d;
  logic               cnt_pulse_q, cnt_pulse_d;
  logic               cnt_clr_n_q, cnt_clr_n_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               accept;
  logic [WIDTH-1:0]   count_inc;
  logic               clr_bad;
  logic               step_bad;

  assign accept    = (state_q == S_IDLE) && start && !abort;
  assign count_inc = count_q + WIDTH'(1);

`ifdef RIPPLE_SEQ_CHECK_EN
  // After a clear the counter must read zero; after a pulse it must read
  // one more than the last verified count.
  assign clr_bad  = (cnt_q != '0);
  assign step_bad = (cnt_q != count_inc);
`else
  // Without checking, cnt_q is never looked at.
  logic unused_cnt_q;
  assign unused_cnt_q = ^cnt_q;
  assign clr_bad      = 1'b0;
  assign step_bad     = 1'b0;
`endif

  // State, wait counter, shadow count, error flag and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      wait_q      <= '0;
      count_q     <= '0;
      error_q     <= 1'b0;
      cnt_pulse_q <= 1'b0;
      cnt_clr_n_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      count_q     <= count_d;
      error_q     <= error_d;
      cnt_pulse_q <= cnt_pulse_d;
      cnt_clr_n_q <= cnt_clr_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Target is plain data captured on an accepted start; it needs no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      target_q <= target;
    end
  end

  // Next-state logic: run sequencing, settle timing and shadow-count update
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    count_d = count_q;
    error_d = error_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_CLEAR;
          wait_d  = WAIT_CLR;
          count_d = '0;
          error_d = 1'b0;
        end
      end
      S_CLEAR: begin
        if (wait_q == '0) begin
          state_d = S_CSETTLE;
          wait_d  = WAIT_SETTLE;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      S_CSETTLE: begin
        if (wait_q == '0) begin
          state_d = S_CCHECK;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      S_CCHECK: begin
        if (clr_bad) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end else if (target_q == '0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_PULSE_H;
        end
      end
      S_PULSE_H: begin
        state_d = S_PULSE_L;
      end
      S_PULSE_L: begin
        state_d = S_SETTLE;
        wait_d  = WAIT_SETTLE;
      end
      S_SETTLE: begin
        if (wait_q == '0) begin
          state_d = S_CHECK;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      S_CHECK: begin
        if (step_bad) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end else begin
          count_d = count_inc;
          state_d = (count_inc == target_q) ? S_DONE : S_PULSE_H;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Abort drops straight back to IDLE, freezing the count and error flag.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      count_d = count_q;
      error_d = error_q;
    end
  end

  // Output logic: decoded from the next state so every output is a flop
  always_comb begin
    cnt_pulse_d = (state_d == S_PULSE_H);
    cnt_clr_n_d = (state_d != S_CLEAR);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
  end

  assign cnt_pulse = cnt_pulse_q;
  assign cnt_clr_n = cnt_clr_n_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign count_out = count_q;
  assign error     = error_q;

endmodule

// File: tb/tb_ripple_cnt_seq.sv
// Testbench for ripple_cnt_seq. It contains a behavioural ripple counter with
// an optional stuck-at-0 stage mask, and an arithmetic reference model of a
// run. The model gives the expected latency, pulse count, final count and
// error flag.
module tb_ripple_cnt_seq;

  localparam int S = 3;
`ifdef RIPPLE_SEQ_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstn;
  logic       start;
  logic       abort;
  logic [3:0] target;
  logic [3:0] cnt_q_w;
  logic       cnt_pulse;
  logic       cnt_clr_n;
  logic       busy;
  logic       done;
  logic [3:0] count_out;
  logic       error;

  int checks = 0;
  int errors = 0;

  ripple_cnt_seq #(.WIDTH(4), .SETTLE(S)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .abort     (abort),
    .target    (target),
    .cnt_q     (cnt_q_w),
    .cnt_pulse (cnt_pulse),
    .cnt_clr_n (cnt_clr_n),
    .busy      (busy),
    .done      (done),
    .count_out (count_out),
    .error     (error)
  );

  always #5 clk = ~clk;

  // Behavioural ripple counter: it counts falling edges of cnt_pulse and
  // clears asynchronously. Its output has a propagation delay, and stages set
  // in the stuck mask read as 0.
  logic [3:0] rc = 4'd0;
  logic [3:0] stuck = 4'd0;
  always @(negedge cnt_pulse or negedge cnt_clr_n) begin
    if (!cnt_clr_n) rc <= 4'd0;
    else            rc <= rc + 4'd1;
  end
  assign #3 cnt_q_w = rc & ~stuck;

  // Free-running counts of cycles with cnt_pulse high and with cnt_clr_n low
  int pulse_cnt = 0;
  int clr_cnt   = 0;
  always @(posedge clk) begin
    if (cnt_pulse === 1'b1) pulse_cnt <= pulse_cnt + 1;
    if (cnt_clr_n === 1'b0) clr_cnt   <= clr_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model. Each step costs S+3 cycles, and so does the clear phase.
  // After k pulses the counter reads k with the stuck stages forced to 0. A
  // run ends after the target number of steps, or at the first step that
  // reads back wrong when checking is enabled.
  function automatic void model(input int t, input logic [3:0] m,
                                output int lat, output int cnt, output bit err, output int np);
    lat = S + 3;
    cnt = 0;
    err = 1'b0;
    np  = 0;
    for (int k = 1; k <= t; k++) begin
      np  = k;
      lat = lat + S + 3;
      if (CHECK_EN && ((k & ~int'(m)) != k)) begin
        err = 1'b1;
        break;
      end
      cnt = k;
    end
  endfunction

  // Start a run, follow it to done, and compare the run against the model
  task automatic run(input logic [3:0] t, output int lat_obs, output int pulses);
    int e_lat, e_cnt, e_np, p0, c0;
    bit e_err, busy_ok;
    model(int'(t), stuck, e_lat, e_cnt, e_err, e_np);
    @(negedge clk);
    target = t;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("accept_busy", busy, 1);
    chk("accept_err_clr", error, 0);
    chk("accept_cnt_clr", count_out, 0);
    p0 = pulse_cnt;
    c0 = clr_cnt;
    busy_ok = 1'b1;
    lat_obs = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) begin
        lat_obs = n;
        break;
      end
    end
    pulses = pulse_cnt - p0;
    chk("run_latency", lat_obs, e_lat);
    chk("run_pulses", pulses, e_np);
    chk("run_count_out", count_out, e_cnt);
    chk("run_error", error, e_err);
    chk("run_busy_held", busy_ok, 1);
    chk("run_clr_cycles", clr_cnt - c0, 2);
    @(posedge clk);
    #1;
    chk("done_one_cycle", done, 0);
    chk("back_idle_busy", busy, 0);
  endtask

  initial begin
    int lat, np;
    bit no_done;
    logic [3:0] one;
    rstn   = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    target = 4'd0;
    one    = 4'b0001;

    // Reset values
    #12;
    chk("rst_cnt_pulse", cnt_pulse, 0);
    chk("rst_cnt_clr_n", cnt_clr_n, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count_out", count_out, 0);
    chk("rst_error", error, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_clr_n", cnt_clr_n, 1);

    // target=2
    run(4'd2, lat, np);
    chk("t2_latency", lat, 18);
    chk("t2_pulses", np, 2);
    chk("t2_count_out", count_out, 2);

    // target=0
    run(4'd0, lat, np);
    chk("t0_latency", lat, 6);
    chk("t0_pulses", np, 0);
    chk("t0_count_out", count_out, 0);

    // target=15, the largest value
    run(4'd15, lat, np);
    chk("t15_latency", lat, 96);
    chk("t15_pulses", np, 15);
    chk("t15_count_out", count_out, 15);
    chk("t15_cnt_q", cnt_q_w, 15);

    // Stage 1 stuck at 0, target=3
    stuck = 4'b0010;
    run(4'd3, lat, np);
    chk("stuck_error", error, CHECK_EN ? 1 : 0);
    chk("stuck_count_out", count_out, CHECK_EN ? 1 : 3);
    chk("stuck_latency", lat, CHECK_EN ? 18 : 24);
    stuck = 4'd0;
    run(4'd4, lat, np);
    chk("after_stuck_error", error, 0);

    // Abort during the SETTLE state of step 2, target=5
    @(negedge clk);
    target = 4'd5;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_count_out", count_out, 1);
    chk("abort_cnt_pulse", cnt_pulse, 0);
    chk("abort_cnt_clr_n", cnt_clr_n, 1);
    no_done = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0) no_done = 1'b0;
    end
    chk("abort_no_done", no_done, 1);
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    chk("abort_start_ignored", busy, 0);
    chk("abort_start_cnt_hold", count_out, 1);

    // rstn pulsed low while cnt_pulse is high
    @(negedge clk);
    target = 4'd3;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_pulse_h", cnt_pulse, 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("midrst_cnt_pulse", cnt_pulse, 0);
    chk("midrst_cnt_clr_n", cnt_clr_n, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_count_out", count_out, 0);
    @(negedge clk);
    rstn = 1'b1;
    run(4'd1, lat, np);
    chk("midrst_t1_latency", lat, 12);

    // Random targets, some with one stage stuck at 0
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 2) == 0) stuck = one << $urandom_range(0, 3);
      else                           stuck = 4'd0;
      run(4'($urandom_range(0, 15)), lat, np);
    end
    stuck = 4'd0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
